snake_speed_controller: RTL and testbench
=========================================

Name: snake_speed_controller

Overview:
- Consumes the 1-cycle enable pulses from the cascaded prescaler counters (BASE_TICK, nominally 1 ms) and issues the MOVE_TICK strobe that advances the snake one cell.
- Owns the game run/pause/over state machine and the speed level.
- Move period shortens as the score rises, with a floor at a minimum period.
- Sits between the tick-counter chain and the snake position/collision logic; that logic returns SCORE_INC and GAME_OVER.

Parameters:
TICK_WIDTH, 8, width of the tick counter and of PERIOD
PERIOD_START, 100, BASE_TICKs per move at level 0
PERIOD_STEP, 8, reduction in period per level
PERIOD_MIN, 20, lower bound on the period; must be >= 1
LEVEL_WIDTH, 4, width of SPEED_LEVEL
LEVEL_MAX, 10, saturation value of the level
POINTS_PER_LEVEL, 4, SCORE_INC pulses per level-up; must be >= 1
POINT_WIDTH, 3, width of the internal point counter

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
BASE_TICK  input  1  one-cycle enable pulse from the upstream counter TRIG_OUT
START  input  1  one-cycle pulse: start or restart a game
PAUSE  input  1  one-cycle pulse: toggle pause
GAME_OVER  input  1  one-cycle pulse from collision logic
SCORE_INC  input  1  one-cycle pulse: food eaten
MOVE_TICK  output  1  registered one-cycle move strobe
LEVEL_UP  output  1  registered one-cycle pulse when the level actually increments
SPEED_LEVEL  output  LEVEL_WIDTH  current level
PERIOD  output  TICK_WIDTH  current move period in BASE_TICKs
STATE  output  2  0 = IDLE, 1 = RUN, 2 = PAUSED, 3 = OVER
RUNNING  output  1  high when STATE == RUN

Behaviour:
Reset
- RESET is synchronous, active-high, on CLK. It has priority over all other inputs, including mid-game.
- Reset values: STATE = IDLE, MOVE_TICK = 0, LEVEL_UP = 0, SPEED_LEVEL = 0, tick counter = 0, point counter = 0.
- PERIOD at reset is PERIOD_START, derived from level 0.

Input evaluation
- All inputs are evaluated against the current (registered) state.
- Transitions take effect on the next edge.

State transitions
- IDLE: on START -> RUN. Level, point counter and tick counter are cleared.
- RUN: on GAME_OVER -> OVER; else on PAUSE -> PAUSED. GAME_OVER has priority over PAUSE.
- PAUSED: on GAME_OVER -> OVER; else on PAUSE -> RUN.
- PAUSED holds the tick counter, level and point counter. The tick count resumes exactly where it stopped.
- OVER: on START -> RUN with level, point counter and tick counter cleared. SPEED_LEVEL is frozen for display until then.
- START in RUN or PAUSED is ignored.

Period
- PERIOD is combinational from the registered level: max(PERIOD_START - level*PERIOD_STEP, PERIOD_MIN).
- The subtraction is computed in a width of at least TICK_WIDTH + LEVEL_WIDTH + 1 bits, as signed. Underflow clamps to PERIOD_MIN and must never wrap.

Tick counter (acts only in RUN with BASE_TICK = 1)
- If tick_cnt >= PERIOD - 1: tick_cnt <= 0 and MOVE_TICK <= 1.
- Otherwise: tick_cnt <= tick_cnt + 1.
- The >= comparison covers a period shrinking below the current count after a level-up: the move fires on the next BASE_TICK.
- MOVE_TICK is 0 on every other cycle. It goes high on the cycle after the edge that sampled the terminal BASE_TICK.
- BASE_TICK is ignored in IDLE, PAUSED and OVER.

Score and level (acts only in RUN)
- On SCORE_INC with point_cnt == POINTS_PER_LEVEL - 1: point_cnt <= 0.
  - If level < LEVEL_MAX: level <= level + 1 and LEVEL_UP <= 1.
  - If level == LEVEL_MAX: level holds and LEVEL_UP stays 0.
- Otherwise on SCORE_INC: point_cnt <= point_cnt + 1.
- SCORE_INC in states other than RUN is ignored.

Simultaneous events
- SCORE_INC and GAME_OVER in the same RUN cycle: the score is counted and the state moves to OVER.
- Terminal BASE_TICK and GAME_OVER in the same RUN cycle: MOVE_TICK still pulses once.
- START and GAME_OVER in the same OVER cycle: START wins.
- A level-up takes effect on PERIOD in the cycle after the SCORE_INC edge.

Test Plan:
1. Params PERIOD_START=5, PERIOD_STEP=1, PERIOD_MIN=3, POINTS_PER_LEVEL=2, LEVEL_MAX=3. RESET, then START, then BASE_TICK every 4th cycle -> MOVE_TICK pulses once per 5 BASE_TICKs, each 1 cycle wide, first one after the 5th BASE_TICK; PERIOD = 5.
2. Same params, 2 SCORE_INC pulses in RUN -> LEVEL_UP pulses once, SPEED_LEVEL = 1, PERIOD = 4. After 6 more SCORE_INC pulses -> SPEED_LEVEL = 3, PERIOD = 3 (level 2 gives 3, level 3 clamps to MIN); the 4th level-up does not raise LEVEL_UP.
3. At tick_cnt = 4 with PERIOD 5, SCORE_INC causes a level-up to PERIOD 4 -> MOVE_TICK fires on the next BASE_TICK and tick_cnt returns to 0.
4. PAUSE after 3 BASE_TICKs, 10 BASE_TICKs while PAUSED, then PAUSE -> no MOVE_TICK while paused; the first MOVE_TICK comes after 2 more BASE_TICKs; SCORE_INC while paused leaves the level unchanged.
5. GAME_OVER and PAUSE in the same cycle -> STATE = 3. START then -> STATE = 1, SPEED_LEVEL = 0, PERIOD = 5.
6. RESET asserted mid-RUN at level 2 in the same cycle as a terminal BASE_TICK -> next cycle STATE = 0, MOVE_TICK = 0, SPEED_LEVEL = 0, LEVEL_UP = 0.

Source files
------------

// File: rtl/snake_speed_controller.sv
// Snake game pacing: divides BASE_TICK into MOVE_TICK strobes, tracks the
// run/pause/over state and raises the speed level as food is eaten.
module snake_speed_controller #(
  parameter int TICK_WIDTH       = 8,
  parameter int PERIOD_START     = 100,
  parameter int PERIOD_STEP      = 8,
  parameter int PERIOD_MIN       = 20,
  parameter int LEVEL_WIDTH      = 4,
  parameter int LEVEL_MAX        = 10,
  parameter int POINTS_PER_LEVEL = 4,
  parameter int POINT_WIDTH      = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   BASE_TICK,
  input  logic                   START,
  input  logic                   PAUSE,
  input  logic                   GAME_OVER,
  input  logic                   SCORE_INC,
  output logic                   MOVE_TICK,
  output logic                   LEVEL_UP,
  output logic [LEVEL_WIDTH-1:0] SPEED_LEVEL,
  output logic [TICK_WIDTH-1:0]  PERIOD,
  output logic [1:0]             STATE,
  output logic                   RUNNING
);

  localparam int SW = TICK_WIDTH + LEVEL_WIDTH + 2;
  localparam logic signed [SW-1:0] START_S = SW'(PERIOD_START);
  localparam logic signed [SW-1:0] STEP_S  = SW'(PERIOD_STEP);
  localparam logic signed [SW-1:0] MIN_S   = SW'(PERIOD_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t                 state_p0;
  state_t                 state_nxt;
  logic [TICK_WIDTH-1:0]  tick_cnt_p0;
  logic [POINT_WIDTH-1:0] point_cnt_p0;
  logic [LEVEL_WIDTH-1:0] level_p0;
  logic                   move_p0;
  logic                   level_up_p0;
  logic [TICK_WIDTH-1:0]  period_m1;
  logic                   clear;
  logic                   run;
  logic                   terminal;

  // Signed wide subtraction so a large level clamps to the floor instead of wrapping.
  function automatic logic [TICK_WIDTH-1:0] sat_period(input logic [LEVEL_WIDTH-1:0] lvl);
    logic signed [SW-1:0] diff;
    diff = START_S - $signed(SW'(lvl)) * STEP_S;
    if (diff < MIN_S) sat_period = TICK_WIDTH'(PERIOD_MIN);
    else              sat_period = TICK_WIDTH'(diff);
  endfunction

  assign PERIOD    = sat_period(level_p0);
  assign period_m1 = PERIOD - TICK_WIDTH'(1);
  assign terminal  = (tick_cnt_p0 >= period_m1);
  assign run       = (state_p0 == RUN);
  assign clear     = START && ((state_p0 == IDLE) || (state_p0 == OVER));

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (GAME_OVER) state_nxt = OVER;
               else if (PAUSE) state_nxt = PAUSED;
      PAUSED:  if (GAME_OVER) state_nxt = OVER;
               else if (PAUSE) state_nxt = RUN;
      default: if (START) state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  // Stage p0: tick divider, score/level counters and registered strobes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt_p0  <= '0;
      point_cnt_p0 <= '0;
      level_p0     <= '0;
      move_p0      <= 1'b0;
      level_up_p0  <= 1'b0;
    end else begin
      move_p0     <= 1'b0;
      level_up_p0 <= 1'b0;
      if (clear) begin
        tick_cnt_p0  <= '0;
        point_cnt_p0 <= '0;
        level_p0     <= '0;
      end else if (run) begin
        if (BASE_TICK) begin
          if (terminal) begin
            tick_cnt_p0 <= '0;
            move_p0     <= 1'b1;
          end else begin
            tick_cnt_p0 <= tick_cnt_p0 + TICK_WIDTH'(1);
          end
        end
        if (SCORE_INC) begin
          if (point_cnt_p0 == POINT_WIDTH'(POINTS_PER_LEVEL - 1)) begin
            point_cnt_p0 <= '0;
            if (level_p0 < LEVEL_WIDTH'(LEVEL_MAX)) begin
              level_p0    <= level_p0 + LEVEL_WIDTH'(1);
              level_up_p0 <= 1'b1;
            end
          end else begin
            point_cnt_p0 <= point_cnt_p0 + POINT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign MOVE_TICK   = move_p0;
  assign LEVEL_UP    = level_up_p0;
  assign SPEED_LEVEL = level_p0;
  assign STATE       = state_p0;
  assign RUNNING     = run;

endmodule

// File: tb/tb_snake_speed_controller.sv
// Bench for snake_speed_controller: directed scenarios plus random traffic,
// every cycle compared against an integer model of the game rules.
module tb_snake_speed_controller;

  localparam int PS = 5, STEP = 1, PMIN = 3, PPL = 2, LMAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bt = 1'b0, st = 1'b0, pa = 1'b0, go = 1'b0, si = 1'b0;
  logic       move_tick, level_up, running;
  logic [3:0] speed_level;
  logic [7:0] period;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // model of the game
  int m_state = 0, m_lvl = 0, m_pts = 0, m_tck = 0, m_mv = 0, m_lu = 0;
  int dut_moves = 0, exp_moves = 0, dut_lus = 0, exp_lus = 0;

  snake_speed_controller #(
    .TICK_WIDTH(8), .PERIOD_START(PS), .PERIOD_STEP(STEP), .PERIOD_MIN(PMIN),
    .LEVEL_WIDTH(4), .LEVEL_MAX(LMAX), .POINTS_PER_LEVEL(PPL), .POINT_WIDTH(3)
  ) dut (
    .CLK(clk), .RESET(rst), .BASE_TICK(bt), .START(st), .PAUSE(pa),
    .GAME_OVER(go), .SCORE_INC(si), .MOVE_TICK(move_tick), .LEVEL_UP(level_up),
    .SPEED_LEVEL(speed_level), .PERIOD(period), .STATE(state), .RUNNING(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_period(input int lvl);
    int p;
    p = PS - lvl * STEP;
    return (p < PMIN) ? PMIN : p;
  endfunction

  task automatic model_step(input bit r, b, s, p, g, i);
    int per;
    if (r) begin
      m_state = 0; m_lvl = 0; m_pts = 0; m_tck = 0; m_mv = 0; m_lu = 0;
      return;
    end
    m_mv = 0; m_lu = 0;
    per = m_period(m_lvl);
    case (m_state)
      0: if (s) begin m_state = 1; m_lvl = 0; m_pts = 0; m_tck = 0; end
      1: begin
        if (b) begin
          if (m_tck >= per - 1) begin m_tck = 0; m_mv = 1; end
          else m_tck++;
        end
        if (i) begin
          m_pts++;
          if (m_pts == PPL) begin
            m_pts = 0;
            if (m_lvl < LMAX) begin m_lvl++; m_lu = 1; end
          end
        end
        if (g) m_state = 3;
        else if (p) m_state = 2;
      end
      2: if (g) m_state = 3; else if (p) m_state = 1;
      default: if (s) begin m_state = 1; m_lvl = 0; m_pts = 0; m_tck = 0; end
    endcase
  endtask

  // compare outputs mid-cycle, then drive the next inputs and advance the model
  task automatic cycle(input bit r, b, s, p, g, i);
    @(negedge clk);
    chk("state", int'(state), m_state);
    chk("running", int'(running), int'(m_state == 1));
    chk("move_tick", int'(move_tick), m_mv);
    chk("level_up", int'(level_up), m_lu);
    chk("speed_level", int'(speed_level), m_lvl);
    chk("period", int'(period), m_period(m_lvl));
    dut_moves += int'(move_tick); exp_moves += m_mv;
    dut_lus += int'(level_up); exp_lus += m_lu;
    rst = r; bt = b; st = s; pa = p; go = g; si = i;
    model_step(r, b, s, p, g, i);
    @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic base_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(0, 1, 0, 0, 0, 0);
      idle_cycles(3);
    end
  endtask

  initial begin
    int mv0, lu0;
    repeat (2) @(posedge clk);

    // 1: move every 5 base ticks from reset/start
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    mv0 = dut_moves;
    base_ticks(25);
    chk("moves_in_25_ticks", dut_moves - mv0, 5);

    // 2: level up on every second score, saturating at LEVEL_MAX
    lu0 = dut_lus;
    cycle(0, 0, 0, 0, 0, 1); idle_cycles(1);
    cycle(0, 0, 0, 0, 0, 1); idle_cycles(2);
    chk("level_after_2", int'(speed_level), 1);
    chk("period_after_2", int'(period), 4);
    for (int k = 0; k < 6; k++) begin cycle(0, 0, 0, 0, 0, 1); idle_cycles(1); end
    idle_cycles(1);
    chk("level_sat", int'(speed_level), 3);
    chk("period_sat", int'(period), 3);
    chk("levelups_total", dut_lus - lu0, 3);

    // 3: period shrinks below the running count -> move on next tick
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 0);
    base_ticks(4);
    cycle(0, 0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0, 1); idle_cycles(1);
    mv0 = dut_moves;
    base_ticks(1);
    chk("move_after_shrink", dut_moves - mv0, 1);
    base_ticks(3);
    chk("count_restart", dut_moves - mv0, 1);
    base_ticks(1);
    chk("next_move_period4", dut_moves - mv0, 2);

    // 4: pause holds counter, level and points
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 0);
    base_ticks(3);
    cycle(0, 0, 0, 1, 0, 0);
    mv0 = dut_moves;
    base_ticks(10);
    cycle(0, 0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0, 1); cycle(0, 0, 1, 0, 0, 0);
    chk("no_move_paused", dut_moves - mv0, 0);
    idle_cycles(1);
    chk("level_paused", int'(speed_level), 0);
    cycle(0, 0, 0, 1, 0, 0);
    base_ticks(1);
    chk("no_move_1_after", dut_moves - mv0, 0);
    base_ticks(1);
    chk("move_2_after", dut_moves - mv0, 1);

    // 5: game over beats pause; restart clears level
    cycle(0, 0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1, 0); idle_cycles(1);
    chk("over_state", int'(state), 3);
    chk("over_level_frozen", int'(speed_level), 1);
    cycle(0, 0, 1, 0, 1, 0); idle_cycles(1);
    chk("restart_state", int'(state), 1);
    chk("restart_level", int'(speed_level), 0);
    chk("restart_period", int'(period), 5);

    // 6: reset at level 2 on a terminal tick
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 1);
    while (m_tck != m_period(m_lvl) - 1) cycle(0, 1, 0, 0, 0, 0);
    chk("pre_reset_level", int'(speed_level), 2);
    cycle(1, 1, 0, 0, 0, 0); idle_cycles(1);
    chk("rst_state", int'(state), 0);
    chk("rst_move", int'(move_tick), 0);
    chk("rst_level", int'(speed_level), 0);
    chk("rst_levelup", int'(level_up), 0);

    // random traffic against the model
    for (int k = 0; k < 4000; k++)
      cycle($urandom_range(499) == 0, $urandom_range(2) == 0, $urandom_range(39) == 0,
            $urandom_range(29) == 0, $urandom_range(59) == 0, $urandom_range(5) == 0);
    idle_cycles(1);
    chk("total_moves", dut_moves, exp_moves);
    chk("total_levelups", dut_lus, exp_lus);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
